// File: rtl/dict_pkg.sv
// Shared sizes and types for the compression dictionary buffer.
// One entry is a 64-byte line built from sixteen 32-bit words.
package dict_pkg;
  localparam int DICT_WORD_W  = 32;
  localparam int DICT_WORDS   = 16;
  localparam int DICT_ENTRY_W = DICT_WORD_W * DICT_WORDS;

  typedef logic [DICT_WORD_W-1:0]  dict_word_t;
  typedef logic [DICT_ENTRY_W-1:0] dict_entry_t;
endpackage

// File: rtl/dict_wr_ctrl.sv
// Write-side bookkeeping for the dictionary entry: slot pointer, word count
// and the full flag. The storage itself lives in fifo_dict.
module dict_wr_ctrl #(
  parameter int WORDS = 16,
  localparam int PW = $clog2(WORDS),
  localparam int CW = $clog2(WORDS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  output logic [PW-1:0] wr_ptr,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [PW-1:0] wr_ptr_next;
  logic [CW-1:0] count_next;

  // A write into a full entry starts the replacement line, so count drops to 1
  // rather than staying saturated; the pointer wraps naturally (power of two).
  always_comb begin
    wr_ptr_next = wr_ptr;
    count_next  = count;
    if (wr) begin
      wr_ptr_next = wr_ptr + PW'(1);
      count_next  = full ? CW'(1) : count + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
    end
  end

  assign full = (count == CW'(WORDS));

endmodule

// File: rtl/fifo_dict.sv
// Single-entry dictionary buffer: accumulates one word per write into a flat
// entry that is exposed continuously to the match logic; full lines are replaced in place.
module fifo_dict
  import dict_pkg::*;
#(
  parameter int DATA_WIDTH      = DICT_WORD_W,
  parameter int WORDS_PER_ENTRY = DICT_WORDS,
  localparam int ENTRY_WIDTH    = DATA_WIDTH * WORDS_PER_ENTRY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [DATA_WIDTH-1:0]  w_data,
  output logic [ENTRY_WIDTH-1:0] r_data,
  output logic                   full
);

  localparam int PW = $clog2(WORDS_PER_ENTRY);
  localparam int CW = $clog2(WORDS_PER_ENTRY) + 1;

  // Writes are never back-pressured: wr alone commits w_data at the edge,
  // there is no ready, and the consumer samples r_data whenever it likes.
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem [WORDS_PER_ENTRY];

  dict_wr_ctrl #(
    .WORDS (WORDS_PER_ENTRY)
  ) u_wr_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .wr_ptr (wr_ptr),
    .count  (count),
    .full   (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < WORDS_PER_ENTRY; k++) mem[k] <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= w_data;
    end
  end

  // Straight wiring of the registers: no read mux between storage and output.
  for (genvar g = 0; g < WORDS_PER_ENTRY; g++) begin : g_view
    assign r_data[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

endmodule

// File: tb/tb_fifo_dict.sv
// Randomized self-checking bench for fifo_dict against a line-level model
// that tracks only the number of writes since reset and the latest word per slot.
module tb_fifo_dict;
  import dict_pkg::*;

  localparam int W  = DICT_WORD_W;
  localparam int N  = DICT_WORDS;
  localparam int EW = DICT_ENTRY_W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr = 1'b0;
  logic [W-1:0]  w_data = '0;
  logic [EW-1:0] r_data;
  logic          full;

  fifo_dict dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .w_data (w_data),
    .r_data (r_data),
    .full   (full)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0]  m_words [N];
  int            m_writes;
  logic [EW-1:0] exp_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic logic [EW-1:0] model_entry();
    logic [EW-1:0] e;
    for (int k = 0; k < N; k++) e[k*W +: W] = m_words[k];
    return e;
  endfunction

  function automatic logic model_full();
    return (m_writes > 0) && (m_writes % N == 0);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) m_words[k] = '0;
    m_writes = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [EW-1:0] exp;
    exp = exp_q.pop_front();
    check({tag, ".r_data"}, r_data, exp);
    check({tag, ".full"}, EW'(full), EW'(model_full()));
  endtask

  // ---------------- drivers ----------------
  task automatic do_write(input logic [W-1:0] d, input string tag);
    @(negedge clk);
    wr = 1'b1;
    w_data = d;
    m_words[m_writes % N] = d;
    m_writes++;
    exp_q.push_back(model_entry());
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_idle(input string tag);
    @(negedge clk);
    wr = 1'b0;
    exp_q.push_back(model_entry());
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  // Reset raised between edges; outputs must clear before any clock edge.
  task automatic do_async_reset(input string tag);
    @(negedge clk);
    wr = 1'b0;
    #2;
    reset = 1'b1;
    model_clear();
    exp_q.push_back(model_entry());
    #1;
    check_state({tag, ".async"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [EW-1:0] fill_const;

  initial begin
    model_clear();

    // Synchronous-style 1-cycle reset with wr low.
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model_entry());
    check_state("reset");
    @(negedge clk);
    reset = 1'b0;

    // Fill 0x0..0xF back to back.
    for (int i = 0; i < N; i++) do_write(W'(i), "fill");
    fill_const = {32'hf, 32'he, 32'hd, 32'hc, 32'hb, 32'ha, 32'h9, 32'h8,
                  32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0};
    check("fill_const", r_data, fill_const);
    check("fill_full", EW'(full), EW'(1));

    for (int i = 0; i < 4; i++) do_idle("idle_hold");

    // Wrap: first 5 words of the next line, old words 5..15 must survive.
    for (int i = 0; i < 5; i++) do_write(W'(32'h10 + i), "wrap_partial");
    check("wrap_partial_w5", EW'(r_data[5*W +: W]), EW'(32'h5));
    for (int i = 5; i < N; i++) do_write(W'(32'h10 + i), "wrap_complete");
    for (int k = 0; k < N; k++) check("wrap_word", EW'(r_data[k*W +: W]), EW'(32'h10 + k));

    // Reset mid-entry, then the next write must land in word 0.
    for (int i = 0; i < 7; i++) do_write(W'(32'hA0 + i), "pre_reset");
    do_async_reset("mid_reset");
    do_write(32'hCAFE_0001, "post_reset");
    check("post_reset_w0", EW'(r_data[W-1:0]), EW'(32'hCAFE_0001));

    // Randomized mix of writes, idles and occasional async resets.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 72) do_write($urandom, "rand_wr");
      else if (r < 98) do_idle("rand_idle");
      else do_async_reset("rand_reset");
    end
    do_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
